// File: rtl/voxel_mem_pkg.sv
// voxel_mem_pkg: shared types and width helpers for the voxel memory arbiter.
//   op_e       - command opcode held in the arbiter's command stage
//   req_id_w   - bits needed to name one of num_req requesters
//   pend_cnt_w - bits needed to count 0..max_pend outstanding reads
package voxel_mem_pkg;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

   function automatic int unsigned req_id_w(input int unsigned num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   function automatic int unsigned pend_cnt_w(input int unsigned max_pend);
      return $clog2(max_pend + 1);
   endfunction

endpackage

// File: rtl/voxel_id_fifo.sv
// voxel_id_fifo: synchronous FIFO of requester IDs, one entry per read
// issued to the SDRAM and not yet answered.
//   clk, reset       - clock, synchronous active-high reset (empties FIFO)
//   push, push_id    - enqueue an ID
//   pop              - dequeue the head (ignored when empty)
//   head_id          - current head entry
//   full, empty      - occupancy flags
// Push and pop in the same cycle are both honoured, including at full.
module voxel_id_fifo
   import voxel_mem_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_id,
   input  logic             pop,
   output logic [WIDTH-1:0] head_id,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = pend_cnt_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head_id = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_id;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/voxel_mem_arbiter.sv
// voxel_mem_arbiter: round-robin arbiter sharing one Avalon-MM master into
// SDRAM between NUM_REQ pipeline requesters.
//   clk, reset                      - single clock, synchronous active-high reset
//   req_valid/req_write/req_addr/
//   req_wdata                       - per-requester command (packed buses)
//   req_ready                       - one-hot grant, combinational
//   rsp_valid, rsp_rdata            - one-hot read-response strobe, shared data
//   avm_*                           - registered command stage to the slave
//   busy                            - stage full or reads outstanding
//   protocol_err                    - sticky: readdatavalid with nothing pending
// Up to MAX_PEND reads may be outstanding; requester IDs are queued at grant
// time and popped on each readdatavalid to route the response.
module voxel_mem_arbiter
   import voxel_mem_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned MAX_PEND = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic [ADDR_W-1:0]         avm_address,
   output logic                      avm_read,
   output logic                      avm_write,
   output logic [DATA_W-1:0]         avm_writedata,
   input  logic                      avm_waitrequest,
   input  logic [DATA_W-1:0]         avm_readdata,
   input  logic                      avm_readdatavalid,
   output logic                      busy,
   output logic                      protocol_err
);

   localparam int unsigned ID_W = req_id_w(NUM_REQ);

   logic               stage_full;
   logic               stage_free;
   logic [NUM_REQ-1:0] elig;
   logic               found;
   logic [ID_W-1:0]    winner;
   logic [ID_W-1:0]    rr;
   logic [ID_W-1:0]    rr_next;
   logic [31:0]        cand;
   logic               grant;
   op_e                win_op;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ID_W-1:0]    head_id;

   // The stage is full exactly when a command is being driven.
   assign stage_full = avm_read | avm_write;
   assign stage_free = !stage_full || !avm_waitrequest;

   // FIFO full is the same as inflight == MAX_PEND; a pop this cycle does
   // not make a read eligible until the next cycle.
   assign elig = req_valid & (req_write | {NUM_REQ{!fifo_full}});

   always_comb begin
      found  = 1'b0;
      winner = rr;
      cand   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = (32'(rr) + k) % NUM_REQ;
         if (!found && elig[ID_W'(cand)]) begin
            found  = 1'b1;
            winner = ID_W'(cand);
         end
      end
   end

   assign rr_next   = ID_W'((32'(winner) + 1) % NUM_REQ);
   assign grant     = found && stage_free && !reset;
   assign win_op    = req_write[winner] ? OP_WRITE : OP_READ;
   assign fifo_push = grant && (win_op == OP_READ);
   assign fifo_pop  = avm_readdatavalid && !fifo_empty;
   assign busy      = stage_full || !fifo_empty;

   always_comb begin
      req_ready = '0;
      if (grant) begin
         req_ready[winner] = 1'b1;
      end
   end

   voxel_id_fifo #(
      .DEPTH (MAX_PEND),
      .WIDTH (ID_W)
   ) u_id_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (fifo_push),
      .push_id (winner),
      .pop     (fifo_pop),
      .head_id (head_id),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         avm_read      <= 1'b0;
         avm_write     <= 1'b0;
         avm_address   <= '0;
         avm_writedata <= '0;
         rr            <= '0;
         rsp_valid     <= '0;
         rsp_rdata     <= '0;
         protocol_err  <= 1'b0;
      end else begin
         if (stage_free) begin
            if (grant) begin
               avm_read      <= (win_op == OP_READ);
               avm_write     <= (win_op == OP_WRITE);
               avm_address   <= req_addr[winner*ADDR_W +: ADDR_W];
               avm_writedata <= req_wdata[winner*DATA_W +: DATA_W];
               rr            <= rr_next;
            end else begin
               avm_read  <= 1'b0;
               avm_write <= 1'b0;
            end
         end

         rsp_valid <= '0;
         if (avm_readdatavalid) begin
            if (fifo_empty) begin
               protocol_err <= 1'b1;
            end else begin
               rsp_valid[head_id] <= 1'b1;
               rsp_rdata          <= avm_readdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_voxel_mem_arbiter.sv
// tb_voxel_mem_arbiter: self-checking bench for voxel_mem_arbiter
// (NUM_REQ=4, ADDR_W=32, DATA_W=16, MAX_PEND=4).
module tb_voxel_mem_arbiter;

   localparam int unsigned NUM_REQ  = 4;
   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned MAX_PEND = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_write;
   logic [127:0] req_addr;
   logic [63:0] req_wdata;
   logic [3:0]  req_ready;
   logic [3:0]  rsp_valid;
   logic [15:0] rsp_rdata;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [15:0] avm_writedata;
   logic        avm_waitrequest;
   logic [15:0] avm_readdata;
   logic        avm_readdatavalid;
   logic        busy;
   logic        protocol_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   voxel_mem_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .MAX_PEND (MAX_PEND)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_write         (req_write),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .req_ready         (req_ready),
      .rsp_valid         (rsp_valid),
      .rsp_rdata         (rsp_rdata),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .busy              (busy),
      .protocol_err      (protocol_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_valid = '0;
      req_write = '0;
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata = '0;
      step();
      reset = 1'b0;
   endtask

   function automatic logic [15:0] slave_data(input logic [31:0] a);
      return a[15:0] ^ a[31:16] ^ 16'h5A5A;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      req_valid = '1;
      req_write = '1;
      req_addr = {4{32'hDEAD_0000}};
      req_wdata = {4{16'hBEEF}};
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata = '0;
      step();
      step();
      #1;
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
      checks++; if ({avm_read, avm_write} !== 2'b00) begin failures++; $display("FAIL rst_rdwr got=%b exp=00", {avm_read, avm_write}); end
      checks++; if (avm_address !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", avm_address); end
      checks++; if (avm_writedata !== 16'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", avm_writedata); end
      checks++; if (rsp_valid !== 4'b0000 || rsp_rdata !== 16'h0) begin failures++; $display("FAIL rst_rsp got=%b/%h exp=0000/0000", rsp_valid, rsp_rdata); end
      checks++; if (busy !== 1'b0 || protocol_err !== 1'b0) begin failures++; $display("FAIL rst_flags got busy=%b err=%b exp=0/0", busy, protocol_err); end
      reset = 1'b0;
      req_valid = '0;
      step();
   endtask

   task automatic test_single_write();
      do_reset();
      req_valid = 4'b0100;
      req_write = 4'b0100;
      req_addr[64 +: 32] = 32'h0000_0100;
      req_wdata[32 +: 16] = 16'hF800;
      #1;
      checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL sw_ready got=%b exp=0100", req_ready); end
      step();
      req_valid = '0;
      #1;
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL sw_ready_after got=%b exp=0000", req_ready); end
      checks++; if ({avm_write, avm_read} !== 2'b10) begin failures++; $display("FAIL sw_cmd got=%b exp=10", {avm_write, avm_read}); end
      checks++; if (avm_address !== 32'h100 || avm_writedata !== 16'hF800) begin failures++; $display("FAIL sw_addr_data got=%h/%h exp=00000100/f800", avm_address, avm_writedata); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sw_busy got=%b exp=1", busy); end
      step();
      #1;
      checks++; if (avm_write !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL sw_idle got write=%b busy=%b exp=0/0", avm_write, busy); end
   endtask

   task automatic test_rotate();
      int unsigned exp_w;
      int unsigned prev;
      do_reset();
      req_valid = '1;
      req_write = '1;
      req_addr = {32'h100C, 32'h1008, 32'h1004, 32'h1000};
      req_wdata = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      exp_w = 0;
      prev = 0;
      for (int unsigned c = 0; c < 8; c++) begin
         #1;
         checks++; if (req_ready !== 4'(1 << exp_w)) begin failures++; $display("FAIL rot_ready[%0d] got=%b exp=%b", c, req_ready, 4'(1 << exp_w)); end
         if (c > 0) begin
            checks++; if (avm_write !== 1'b1 || avm_address !== 32'h1000 + prev * 4) begin failures++; $display("FAIL rot_cmd[%0d] got=%b/%h exp=1/%h", c, avm_write, avm_address, 32'h1000 + prev * 4); end
         end
         prev = exp_w;
         exp_w = (exp_w + 1) % NUM_REQ;
         step();
      end
      req_valid = '0;
      #1;
      checks++; if (avm_address !== 32'h1000 + prev * 4) begin failures++; $display("FAIL rot_last got=%h exp=%h", avm_address, 32'h1000 + prev * 4); end
      step();
   endtask

   task automatic test_waitrequest();
      do_reset();
      req_valid = '1;
      req_write = '1;
      req_addr = {32'h100C, 32'h1008, 32'h1004, 32'h1000};
      req_wdata = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      #1;
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL wr_first got=%b exp=0001", req_ready); end
      step();
      avm_waitrequest = 1'b1;
      for (int unsigned c = 0; c < 5; c++) begin
         #1;
         checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL wr_stall_ready[%0d] got=%b exp=0000", c, req_ready); end
         checks++; if (avm_write !== 1'b1 || avm_address !== 32'h1000 || avm_writedata !== 16'h1111) begin failures++; $display("FAIL wr_stall_cmd[%0d] got=%b/%h/%h exp=1/00001000/1111", c, avm_write, avm_address, avm_writedata); end
         step();
      end
      avm_waitrequest = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL wr_accept_ready got=%b exp=0010", req_ready); end
      step();
      req_valid = '0;
      #1;
      checks++; if (avm_address !== 32'h1004 || avm_writedata !== 16'h2222) begin failures++; $display("FAIL wr_next_cmd got=%h/%h exp=00001004/2222", avm_address, avm_writedata); end
      step();
   endtask

   task automatic test_read_limit();
      do_reset();
      req_valid = 4'b0010;
      req_write = 4'b0000;
      req_addr[32 +: 32] = 32'h2000;
      #1;
      checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rl_grant0 got=%b exp=0010", req_ready); end
      for (int unsigned g = 1; g < 4; g++) begin
         step();
         req_addr[32 +: 32] = 32'h2000 + g;
         #1;
         checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rl_grant[%0d] got=%b exp=0010", g, req_ready); end
         checks++; if (avm_read !== 1'b1 || avm_address !== 32'h2000 + g - 1) begin failures++; $display("FAIL rl_cmd[%0d] got=%b/%h exp=1/%h", g, avm_read, avm_address, 32'h2000 + g - 1); end
      end
      step();
      req_addr[32 +: 32] = 32'h2004;
      #1;
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rl_full_ready got=%b exp=0000", req_ready); end
      step();
      #1;
      checks++; if (req_ready !== 4'b0000 || avm_read !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL rl_stalled got=%b/%b/%b exp=0000/0/1", req_ready, avm_read, busy); end
      step();
      avm_readdatavalid = 1'b1;
      avm_readdata = 16'hA001;
      #1;
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rl_pop_cycle_ready got=%b exp=0000", req_ready); end
      step();
      avm_readdatavalid = 1'b0;
      #1;
      checks++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 16'hA001) begin failures++; $display("FAIL rl_rsp1 got=%b/%h exp=0010/a001", rsp_valid, rsp_rdata); end
      checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rl_regrant got=%b exp=0010", req_ready); end
      step();
      req_valid = '0;
      #1;
      checks++; if (avm_read !== 1'b1 || avm_address !== 32'h2004 || rsp_valid !== 4'b0000) begin failures++; $display("FAIL rl_fifth got=%b/%h/%b exp=1/00002004/0000", avm_read, avm_address, rsp_valid); end
      for (int unsigned k = 2; k <= 5; k++) begin
         step();
         avm_readdatavalid = 1'b1;
         avm_readdata = 16'hA000 + 16'(k);
         step();
         avm_readdatavalid = 1'b0;
         #1;
         checks++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 16'hA000 + 16'(k)) begin failures++; $display("FAIL rl_rsp[%0d] got=%b/%h exp=0010/%h", k, rsp_valid, rsp_rdata, 16'hA000 + 16'(k)); end
      end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rl_busy_end got=%b exp=0", busy); end
   endtask

   // Randomized traffic against a queue-based model: a request stream per
   // requester, a list of pending read owners in grant order, and a slave
   // that returns one data word per accepted read, in order, after a delay.
   task automatic test_random(input logic [3:0] mask, input int unsigned ncyc);
      logic        sv, sw;
      logic [31:0] sa;
      logic [15:0] sd;
      logic [1:0]  pend[$];
      logic [15:0] slave_q[$];
      logic [3:0]  exp_rv, elig, exp_ready;
      logic [15:0] exp_rd;
      logic [1:0]  rr_m, w, j;
      logic        found, rdv_now, free;
      int unsigned c;
      do_reset();
      sv = 1'b0; sw = 1'b0; sa = '0; sd = '0;
      exp_rv = '0; exp_rd = '0; rr_m = '0; c = 0;
      while ((c < ncyc || sv || pend.size() != 0 || exp_rv != 0) && c < ncyc + 200) begin
         checks++; if ({avm_read, avm_write} !== {sv & ~sw, sv & sw}) begin failures++; $display("FAIL rnd_rdwr[%0d] got=%b exp=%b", c, {avm_read, avm_write}, {sv & ~sw, sv & sw}); end
         if (sv) begin
            checks++; if (avm_address !== sa || avm_writedata !== sd) begin failures++; $display("FAIL rnd_cmd[%0d] got=%h/%h exp=%h/%h", c, avm_address, avm_writedata, sa, sd); end
         end
         checks++; if (rsp_valid !== exp_rv) begin failures++; $display("FAIL rnd_rsp_valid[%0d] got=%b exp=%b", c, rsp_valid, exp_rv); end
         if (exp_rv != 0) begin
            checks++; if (rsp_rdata !== exp_rd) begin failures++; $display("FAIL rnd_rsp_data[%0d] got=%h exp=%h", c, rsp_rdata, exp_rd); end
         end
         checks++; if (busy !== (sv || pend.size() != 0)) begin failures++; $display("FAIL rnd_busy[%0d] got=%b exp=%b", c, busy, (sv || pend.size() != 0)); end

         if (c < ncyc) begin
            req_valid = mask & (4'($urandom) | 4'($urandom));
            req_write = 4'($urandom);
            req_addr = {$urandom, $urandom, $urandom, $urandom};
            req_wdata = {$urandom, $urandom};
            avm_waitrequest = ($urandom_range(0, 3) == 0);
         end else begin
            req_valid = '0;
            avm_waitrequest = 1'b0;
         end
         rdv_now = (slave_q.size() != 0) && (c >= ncyc || $urandom_range(0, 1) == 1);
         avm_readdatavalid = rdv_now;
         avm_readdata = rdv_now ? slave_q[0] : 16'($urandom);
         #1;

         free = !sv || !avm_waitrequest;
         elig = req_valid & (req_write | ((pend.size() < MAX_PEND) ? 4'hF : 4'h0));
         found = 1'b0;
         w = '0;
         if (free) begin
            for (int k = 0; k < 4; k++) begin
               j = rr_m + 2'(k);
               if (!found && elig[j]) begin
                  found = 1'b1;
                  w = j;
               end
            end
         end
         exp_ready = found ? (4'b0001 << w) : 4'b0000;
         checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, req_ready, exp_ready); end

         exp_rv = '0;
         if (rdv_now) begin
            exp_rd = avm_readdata;
            exp_rv = 4'b0001 << pend.pop_front();
            void'(slave_q.pop_front());
         end
         if (sv && !avm_waitrequest && !sw) begin
            slave_q.push_back(slave_data(sa));
         end
         if (free) begin
            if (found) begin
               sv = 1'b1;
               sw = req_write[w];
               sa = req_addr[w*32 +: 32];
               sd = req_wdata[w*16 +: 16];
               rr_m = w + 2'd1;
               if (!sw) pend.push_back(w);
            end else begin
               sv = 1'b0;
            end
         end
         c++;
         step();
      end
      checks++; if (c >= ncyc + 200) begin failures++; $display("FAIL rnd_drain got=%0d cycles exp<%0d", c, ncyc + 200); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rnd_idle got=%b exp=0", busy); end
   endtask

   task automatic test_protocol_err();
      do_reset();
      avm_readdatavalid = 1'b1;
      avm_readdata = 16'hBEEF;
      step();
      avm_readdatavalid = 1'b0;
      #1;
      checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL perr_set got=%b exp=1", protocol_err); end
      checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL perr_ignored got=%b/%b exp=0000/0", rsp_valid, busy); end
      req_valid = 4'b0001;
      req_write = 4'b0001;
      step();
      req_valid = '0;
      step();
      step();
      #1;
      checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL perr_sticky got=%b exp=1", protocol_err); end
      do_reset();
      #1;
      checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL perr_clear got=%b exp=0", protocol_err); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid = 4'b0010;
      req_write = 4'b0000;
      req_addr[32 +: 32] = 32'h3000;
      step();
      step();
      step();
      req_valid = '0;
      step();
      #1;
      checks++; if (busy !== 1'b1 || avm_read !== 1'b0) begin failures++; $display("FAIL rm_pending got=%b/%b exp=1/0", busy, avm_read); end
      reset = 1'b1;
      req_valid = 4'b0100;
      req_addr[64 +: 32] = 32'h4000;
      #1;
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rm_ready_in_reset got=%b exp=0000", req_ready); end
      step();
      #1;
      checks++; if (busy !== 1'b0 || {avm_read, avm_write} !== 2'b00 || rsp_valid !== 4'b0000) begin failures++; $display("FAIL rm_cleared got=%b/%b/%b exp=0/00/0000", busy, {avm_read, avm_write}, rsp_valid); end
      reset = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL rm_regrant got=%b exp=0100", req_ready); end
      step();
      req_valid = '0;
      #1;
      checks++; if (avm_read !== 1'b1 || avm_address !== 32'h4000) begin failures++; $display("FAIL rm_cmd got=%b/%h exp=1/00004000", avm_read, avm_address); end
      step();
      avm_readdatavalid = 1'b1;
      avm_readdata = 16'hC0DE;
      step();
      avm_readdatavalid = 1'b0;
      #1;
      checks++; if (rsp_valid !== 4'b0100 || rsp_rdata !== 16'hC0DE) begin failures++; $display("FAIL rm_rsp got=%b/%h exp=0100/c0de", rsp_valid, rsp_rdata); end
      checks++; if (busy !== 1'b0 || protocol_err !== 1'b0) begin failures++; $display("FAIL rm_final got=%b/%b exp=0/0", busy, protocol_err); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr = '0;
      req_wdata = '0;
      avm_waitrequest = 1'b0;
      avm_readdata = '0;
      avm_readdatavalid = 1'b0;
      test_reset();
      test_single_write();
      test_rotate();
      test_waitrequest();
      test_read_limit();
      test_random(4'b1001, 300);
      test_random(4'b1111, 400);
      test_protocol_err();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/voxel_mem_arbiter.md
# voxel_mem_arbiter

Round-robin arbiter that shares the single Avalon-MM master path into the FPGA SDRAM between N voxel-pipeline requesters (ray/raster cores writing pixels, texture/voxel fetch units reading). Requesters use valid/ready; the arbiter drives one registered command stage onto the bus, supports pipelined reads with up to MAX_PEND outstanding, and routes each read response to the requester that issued it. It sits between the GPU cores and the SDRAM controller slave inside the Computer_System fabric.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, Avalon byte address width
- DATA_W, 16, data width (one RGB565 pixel)
- MAX_PEND, 4, maximum outstanding reads (power of two, 2..16)
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] && req_ready[i]
- rsp_valid  out  NUM_REQ  one-hot read-response strobe
- rsp_rdata  out  DATA_W  read data, shared by all requesters
- avm_address  out  ADDR_W; avm_read, avm_write  out  1; avm_writedata  out  DATA_W
- avm_waitrequest  in  1; avm_readdata  in  DATA_W; avm_readdatavalid  in  1
- busy  out  1  stage occupied or reads outstanding
- protocol_err  out  1  sticky: readdatavalid with no read outstanding

## Operation
- Command stage: one register set (op, addr, wdata); drives avm_* while full. Empty stage drives avm_read = avm_write = 0.
- Stage "free" = empty, or full and !avm_waitrequest (being accepted this cycle). Grant happens only when free.
- Eligibility: requester i eligible if req_valid[i] and (req_write[i] or inflight < MAX_PEND).
- Winner: first eligible index searching rr, rr+1, ... modulo NUM_REQ. req_ready[winner] = 1 (combinational, at most one bit); stage loads winner's command; rr <= (winner+1) mod NUM_REQ. No eligible requester: rr unchanged, stage empties if accepted.
- Read grant: push winner ID into ID FIFO, inflight += 1 at grant time (issue order equals grant order).
- avm_readdatavalid: pop FIFO head h; next cycle rsp_valid[h] = 1, rsp_rdata = registered readdata. Grant and pop same cycle: inflight unchanged, push and pop both performed.
- readdatavalid with inflight == 0: ignored, protocol_err set until reset.
- Writes are never blocked by outstanding reads; ordering is the slave's in-order guarantee.
- busy = stage full or inflight != 0.

## Timing
- Reset values: avm_read/avm_write/avm_address/avm_writedata 0, req_ready 0 (forced 0 while reset high), rsp_valid 0, rsp_rdata 0, protocol_err 0, busy 0, rr 0, inflight 0, FIFO empty.
- Grant to avm command: 1 cycle (command on bus the cycle after req_valid&&req_ready).
- Throughput: one command per cycle with waitrequest low; command held stable while waitrequest high.
- Read response: rsp_valid 1 cycle after avm_readdatavalid.
- inflight == MAX_PEND: all reads ineligible; earliest re-grant is the cycle after the decrementing readdatavalid.
- Reset mid-operation: stage dropped, FIFO and inflight cleared in the same edge; slave is reset by the same signal.

## Structure
- Package voxel_mem_pkg: REQ_ID_W = $clog2(NUM_REQ) helper, op encoding constants (OP_READ, OP_WRITE), pending-count width function.
- Sub-module voxel_id_fifo: synchronous FIFO, depth MAX_PEND, width REQ_ID_W, push/pop/full/empty, simultaneous push+pop at full or empty legal.
- Round-robin search and command stage stay in voxel_mem_arbiter.

## Test plan
- Single write from req 2 (addr 0x0000_0100, data 0xF800), waitrequest low -> req_ready=0100 one cycle, avm_write with that addr/data next cycle, busy drops after.
- All 4 requesters write continuously, waitrequest low -> grants rotate 0,1,2,3,0 with one command per cycle.
- waitrequest held high 5 cycles with stage full -> avm_* stable, no req_ready asserted, then accepted and next grant follows.
- Req 1 issues 5 reads, slave delays readdatavalid -> 4 issued, 5th stalled until first readdatavalid; responses 0xA001..0xA005 appear on rsp_valid[1] in order, 1 cycle after each readdatavalid.
- Interleaved reads from req 0 and req 3 -> responses routed to matching rsp_valid bit in issue order; readdatavalid with nothing outstanding -> protocol_err=1 and stays until reset.
- Assert reset with 3 reads outstanding -> all outputs at reset values next cycle, inflight 0, first new read granted normally.
